// File: rtl/mux_arbiter_pkg.sv
// Shared definitions for the mux_arbiter slice: state encoding, clog2 helper, default width.
package arb_defs;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 16;

  // Ceiling log2; returns 0 for 1 so single-entry widths collapse cleanly.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_arbiter_rr_pick.sv
// Rotate-and-priority-encode: first set req bit at or above ptr, wrapping modulo N_REQ.
module rr_pick
  import arb_defs::*;
#(
  parameter  int N_REQ = 4,
  localparam int IW    = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] pick,
  output logic [IW-1:0]    idx,
  output logic             any
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    pick  = '0;
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    any   = |req;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IW'((int'(ptr) + k) % N_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    for (int k = 0; k < N_REQ; k++) begin
      pick[k] = any && (idx == IW'(k));
    end
  end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin burst arbiter driving an N_REQ:1 word mux tree with valid/ready on both sides.
// Define ARB_FIXED_PRIO_EN to replace round-robin with lowest-index-wins (no rr_ptr).
module mux_arbiter
  import arb_defs::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int WIDTH     = DEFAULT_WIDTH,
  parameter  int MAX_BURST = 4,
  localparam int IW        = clog2(N_REQ),
  localparam int BW        = clog2(MAX_BURST + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   out_ready,
  output logic [N_REQ-1:0]       grant,
  output logic [IW-1:0]          grant_idx
);

  localparam int P = 1 << IW;

  state_t           state_reg, state_next;
  logic [N_REQ-1:0] grant_reg, grant_next;
  logic [IW-1:0]    idx_reg, idx_next;
  logic [BW-1:0]    beat_cnt_reg, beat_cnt_next;
  logic [IW-1:0]    pick_ptr;
  logic [N_REQ-1:0] pick_onehot;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic             beat;
  logic             last_beat;
  logic [IW-1:0]    next_ptr;
  logic [WIDTH-1:0] mux_out;

`ifdef ARB_FIXED_PRIO_EN
  assign pick_ptr = '0;
`else
  logic [IW-1:0] rr_ptr_reg, rr_ptr_next;
  assign pick_ptr = rr_ptr_reg;
`endif

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req  (req_valid),
    .ptr  (pick_ptr),
    .pick (pick_onehot),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign beat      = (state_reg == GRANT) && req_valid[idx_reg] && out_ready;
  assign last_beat = (beat_cnt_reg == BW'(MAX_BURST - 1));
  assign next_ptr  = (idx_reg == IW'(N_REQ - 1)) ? '0 : idx_reg + 1'b1;

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    idx_next      = idx_reg;
    beat_cnt_next = beat_cnt_reg;
`ifndef ARB_FIXED_PRIO_EN
    rr_ptr_next   = rr_ptr_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (pick_any) begin
          state_next    = GRANT;
          grant_next    = pick_onehot;
          idx_next      = pick_idx;
          beat_cnt_next = '0;
        end
      end
      GRANT: begin
        // Burst limit wins over continued hold; a dropped valid ends the grant early.
        if (!req_valid[idx_reg] || (beat && last_beat)) begin
          state_next    = IDLE;
          grant_next    = '0;
          idx_next      = '0;
          beat_cnt_next = '0;
`ifndef ARB_FIXED_PRIO_EN
          rr_ptr_next   = next_ptr;
`endif
        end else if (beat) begin
          beat_cnt_next = beat_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      idx_reg      <= '0;
      beat_cnt_reg <= '0;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr_reg   <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      idx_reg      <= idx_next;
      beat_cnt_reg <= beat_cnt_next;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr_reg   <= rr_ptr_next;
`endif
    end
  end

  // Binary tree of 2:1 muxes; level gl consumes select bit gl of the grant index.
  logic [WIDTH-1:0] leaf [P];

  genvar gi, gl;
  generate
    for (gi = 0; gi < P; gi++) begin : g_leaf
      if (gi < N_REQ) begin : g_real
        assign leaf[gi] = req_data[gi*WIDTH +: WIDTH];
      end else begin : g_pad
        assign leaf[gi] = '0;
      end
    end
    for (gl = 0; gl < IW; gl++) begin : stg
      logic [WIDTH-1:0] n [P >> (gl + 1)];
      for (gi = 0; gi < (P >> (gl + 1)); gi++) begin : g_node
        if (gl == 0) begin : g_from_leaf
          assign n[gi] = idx_reg[gl] ? leaf[2*gi+1] : leaf[2*gi];
        end else begin : g_from_stage
          assign n[gi] = idx_reg[gl] ? stg[gl-1].n[2*gi+1] : stg[gl-1].n[2*gi];
        end
      end
    end
  endgenerate

  assign mux_out   = stg[IW-1].n[0];
  assign grant     = grant_reg;
  assign grant_idx = idx_reg;
  assign out_valid = (state_reg == GRANT) && req_valid[idx_reg];
  assign out_data  = (state_reg == GRANT) ? mux_out : '0;
  assign req_ready = grant_reg & {N_REQ{out_ready}};

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter: per-cycle reference model plus directed grant/beat logs.
module tb_mux_arbiter;

  localparam int NR = 4;
  localparam int W  = 16;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*W-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic            out_ready = 1'b0;
  logic [NR-1:0]   grant;
  logic [1:0]      grant_idx;

  mux_arbiter #(.N_REQ(NR), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: who owns the bus, how many beats served, where the search starts.
  bit m_init = 1'b0;
  bit m_busy = 1'b0;
  int m_owner = 0;
  int m_beats = 0;
  int m_ptr = 0;

  // Observed grants from the DUT: owner, beats served, idle cycles before it.
  int g_log [32];
  int b_log [32];
  int gap_log [32];
  int ng = 0;
  int gap = 0;
  int stall_cnt = 0;
  logic [NR-1:0] prev_grant = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    int c;
    if (!rst_n) begin
      m_init  = 1'b1;
      m_busy  = 1'b0;
      m_owner = 0;
      m_beats = 0;
      m_ptr   = 0;
    end else if (m_init) begin
      if (!m_busy) begin
        for (int k = 0; k < NR; k++) begin
          c = (m_ptr + k) % NR;
          if (!m_busy && req_valid[c]) begin
            m_busy  = 1'b1;
            m_owner = c;
            m_beats = 0;
          end
        end
      end else if (!req_valid[m_owner] || (out_ready && m_beats + 1 == MB)) begin
        m_busy = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
        m_ptr  = (m_owner + 1) % NR;
`endif
      end else if (out_ready) begin
        m_beats = m_beats + 1;
      end
    end
  endtask

  task automatic compare_outputs();
    logic [NR-1:0] e_grant;
    logic [NR-1:0] e_ready;
    logic [W-1:0]  e_data;
    logic          e_valid;
    int            e_idx;
    e_grant = '0;
    e_data  = '0;
    e_idx   = 0;
    e_valid = 1'b0;
    if (m_busy) begin
      e_grant[m_owner] = 1'b1;
      e_idx   = m_owner;
      e_data  = req_data[m_owner*W +: W];
      e_valid = req_valid[m_owner];
    end
    e_ready = e_grant & {NR{out_ready}};
    checks++;
    if (grant !== e_grant || int'(grant_idx) != e_idx || out_valid !== e_valid ||
        req_ready !== e_ready || out_data !== e_data) begin
      failures++;
      $display("FAIL cycle t=%0t actual grant=%b idx=%0d valid=%b ready=%b data=%h required grant=%b idx=%0d valid=%b ready=%b data=%h",
               $time, grant, grant_idx, out_valid, req_ready, out_data,
               e_grant, e_idx, e_valid, e_ready, e_data);
    end
    check("onehot", 64'($countones(grant) <= 1), 64'd1);
  endtask

  task automatic log_dut();
    if (grant != '0) begin
      if (prev_grant == '0 && ng < 32) begin
        g_log[ng]   = int'(grant_idx);
        b_log[ng]   = 0;
        gap_log[ng] = gap;
        ng++;
      end
      if (out_valid && out_ready && ng > 0) b_log[ng-1] = b_log[ng-1] + 1;
      if (out_valid && !out_ready) stall_cnt++;
      gap = 0;
    end else begin
      gap++;
    end
    prev_grant = grant;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (m_init) begin
        compare_outputs();
        log_dut();
      end
    end
  end

  task automatic clear_logs();
    for (int i = 0; i < 32; i++) begin
      g_log[i]   = -1;
      b_log[i]   = -1;
      gap_log[i] = -1;
    end
    ng = 0;
    gap = 0;
    stall_cnt = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic start(input logic [NR-1:0] v, input logic rdy);
    rst_n     = 1'b0;
    req_valid = v;
    out_ready = rdy;
    cyc(2);
    clear_logs();
    rst_n = 1'b1;
  endtask

  int exp_fair [5];
  int exp_mid [3];

  initial begin
    for (int i = 0; i < NR; i++) req_data[i*W +: W] = W'(16'h1111 * (i + 1));
`ifdef ARB_FIXED_PRIO_EN
    exp_fair = '{0, 0, 0, 0, 0};
    exp_mid  = '{0, 0, 0};
`else
    exp_fair = '{0, 1, 2, 3, 0};
    exp_mid  = '{0, 1, 0};
`endif
    clear_logs();

    // Reset with every requester asking.
    rst_n = 1'b0;
    req_valid = '1;
    out_ready = 1'b1;
    cyc(2);
    #2;
    check("reset_grant", 64'(grant), 64'd0);
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_ready", 64'(req_ready), 64'd0);
    rst_n = 1'b1;
    cyc(1);
    #2;
    check("first_grant", 64'(grant), 64'b0001);
    check("first_data", 64'(out_data), 64'h1111);

    // Single requester 2.
    req_data[2*W +: W] = 16'hBEEF;
    start(4'b0100, 1'b1);
    cyc(1);
    #2;
    check("single_data", 64'(out_data), 64'hBEEF);
    cyc(11);
    check("single_ngrants", 64'(ng), 64'd3);
    check("single_g0", 64'(g_log[0]), 64'd2);
    check("single_g1", 64'(g_log[1]), 64'd2);
    check("single_b0", 64'(b_log[0]), 64'd4);
    check("single_b1", 64'(b_log[1]), 64'd4);
    check("single_gap", 64'(gap_log[1]), 64'd1);

    // Fairness with all four requesting.
    start('1, 1'b1);
    cyc(25);
    check("fair_ngrants", 64'(ng), 64'd5);
    for (int i = 0; i < 5; i++) check($sformatf("fair_g%0d", i), 64'(g_log[i]), 64'(exp_fair[i]));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fair_b%0d", i), 64'(b_log[i]), 64'd4);
      check($sformatf("fair_gap%0d", i + 1), 64'(gap_log[i+1]), 64'd1);
    end

    // Backpressure on requester 1.
    start(4'b0010, 1'b0);
    cyc(3);
    #2;
    check("stall_grant", 64'(grant), 64'b0010);
    check("stall_valid", 64'(out_valid), 64'd1);
    check("stall_ready", 64'(req_ready), 64'd0);
    cyc(3);
    out_ready = 1'b1;
    cyc(6);
    check("stall_g0", 64'(g_log[0]), 64'd1);
    check("stall_cycles", 64'(stall_cnt), 64'd5);
    check("stall_b0", 64'(b_log[0]), 64'd4);

    // Early release by requester 3 after two beats.
    start(4'b1000, 1'b1);
    cyc(3);
    req_valid = 4'b0011;
    cyc(4);
    check("early_g0", 64'(g_log[0]), 64'd3);
    check("early_b0", 64'(b_log[0]), 64'd2);
    check("early_g1", 64'(g_log[1]), 64'd0);
    check("early_gap", 64'(gap_log[1]), 64'd1);

    // Reset in the middle of requester 1's burst.
    start('1, 1'b1);
    cyc(7);
    rst_n = 1'b0;
    cyc(1);
    #2;
    check("midrst_grant", 64'(grant), 64'd0);
    check("midrst_idx", 64'(grant_idx), 64'd0);
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_ready", 64'(req_ready), 64'd0);
    check("midrst_data", 64'(out_data), 64'd0);
    cyc(1);
    rst_n = 1'b1;
    cyc(3);
    check("midrst_ngrants", 64'(ng), 64'd3);
    for (int i = 0; i < 3; i++) check($sformatf("midrst_g%0d", i), 64'(g_log[i]), 64'(exp_mid[i]));

    req_valid = '0;
    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
